// File: rtl/song_pkg.sv
// Shared types for the song sequencer: note index/duration widths and FSM states.
// Pure declarations; no timing or flow control of its own.
package song_pkg;
  localparam int IDX_W = 11;
  localparam int DUR_W = 29;

  typedef logic [IDX_W-1:0] note_idx_t;
  typedef logic [DUR_W-1:0] note_dur_t;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} seq_state_t;
endpackage

// File: rtl/song_sequencer_if.sv
// Control, ROM and status bundle between the player controls/ROMs and the sequencer.
// Level and pulse signals only; the sequencer never stalls its controller.
interface song_sequencer_if;
  import song_pkg::*;

  logic      start;
  logic      stop;
  logic      pause;
  logic      loop_en;
  note_dur_t note_dur;
  note_idx_t note_index;
  logic      note_on;
  logic      busy;
  logic      song_done;

  modport master (
    output start, stop, pause, loop_en, note_dur,
    input  note_index, note_on, busy, song_done
  );

  modport slave (
    input  start, stop, pause, loop_en, note_dur,
    output note_index, note_on, busy, song_done
  );
endinterface

// File: rtl/dur_counter.sv
// Loadable down-counter with zero-clamped load; expire is combinational (count==1 && en).
// Load/clear take effect next edge; en=0 simply holds the count.
module dur_counter
  import song_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr,
  input  logic      load,
  input  note_dur_t load_val,
  input  logic      en,
  output logic      expire
);

  note_dur_t cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_val == '0) ? note_dur_t'(1) : load_val;
    end else if (en && cnt != '0) begin
      // Expiry is decided on the pre-decrement value, so the count never wraps.
      cnt <= cnt - note_dur_t'(1);
    end
  end

  assign expire = en && (cnt == note_dur_t'(1));

endmodule

// File: rtl/song_sequencer.sv
// Steps through a song's notes, timing each from the duration ROM plus an optional gap.
// Outputs are registered (1-cycle latency from controls); pause freezes PLAY/GAP timing only.
module song_sequencer
  import song_pkg::*;
#(
  parameter int NUM_NOTES  = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  song_sequencer_if.slave  bus
);

  localparam note_idx_t LAST_IDX = note_idx_t'(NUM_NOTES - 1);
  localparam note_dur_t GAP_VAL  = note_dur_t'(GAP_CYCLES);
  localparam bit        HAS_GAP  = (GAP_CYCLES > 0);

  seq_state_t state, state_nxt;
  note_idx_t  note_index, idx_nxt;
  logic       note_on, busy, song_done;
  logic       dur_exp, gap_exp, gap_load, advance;

  dur_counter u_dur (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.stop),
    .load     (state == LOAD),
    .load_val (bus.note_dur),
    .en       ((state == PLAY) && !bus.pause),
    .expire   (dur_exp)
  );

  dur_counter u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.stop),
    .load     (gap_load),
    .load_val (GAP_VAL),
    .en       ((state == GAP) && !bus.pause),
    .expire   (gap_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      note_index <= '0;
      note_on    <= 1'b0;
      busy       <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      note_index <= idx_nxt;
      note_on    <= (state_nxt == PLAY);
      busy       <= (state_nxt == LOAD) || (state_nxt == PLAY) || (state_nxt == GAP);
      song_done  <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = note_index;
    gap_load  = 1'b0;
    advance   = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = LOAD;
          idx_nxt   = '0;
        end
      end
      LOAD: state_nxt = PLAY;
      PLAY: begin
        if (dur_exp) begin
          if (HAS_GAP) begin
            state_nxt = GAP;
            gap_load  = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      GAP:     advance   = gap_exp;
      default: state_nxt = IDLE;
    endcase

    if (advance) begin
      if (note_index < LAST_IDX) begin
        idx_nxt   = note_index + note_idx_t'(1);
        state_nxt = LOAD;
      end else if (bus.loop_en) begin
        idx_nxt   = '0;
        state_nxt = LOAD;
      end else begin
        state_nxt = DONE;
      end
    end

    // stop overrides start and any advance decided above
    if (bus.stop) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      gap_load  = 1'b0;
    end
  end

  assign bus.note_index = note_index;
  assign bus.note_on    = note_on;
  assign bus.busy       = busy;
  assign bus.song_done  = song_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: three instances (4 notes/no gap, 4 notes/gap 2, 2 notes) against a note-period model.
module tb_song_sequencer;
  import song_pkg::*;

  logic clk;
  bit   rst_n;
  bit   st[3], sp[3], pa[3], lp[3];
  logic [28:0] rom[3][4];

  int NN[3] = '{4, 4, 2};
  int GG[3] = '{0, 2, 0};

  // model: activity flag, finished flag, note index, cycle position inside the note period
  bit m_act[3], m_done[3];
  int m_idx[3], m_pos[3];

  int ntests = 0;
  int nfail  = 0;

  logic [10:0] o_idx[3];
  logic        o_on[3], o_busy[3], o_done[3];

  song_sequencer_if i0 ();
  song_sequencer_if i1 ();
  song_sequencer_if i2 ();

  assign i0.start = st[0]; assign i0.stop = sp[0]; assign i0.pause = pa[0]; assign i0.loop_en = lp[0];
  assign i1.start = st[1]; assign i1.stop = sp[1]; assign i1.pause = pa[1]; assign i1.loop_en = lp[1];
  assign i2.start = st[2]; assign i2.stop = sp[2]; assign i2.pause = pa[2]; assign i2.loop_en = lp[2];
  assign i0.note_dur = rom[0][i0.note_index[1:0]];
  assign i1.note_dur = rom[1][i1.note_index[1:0]];
  assign i2.note_dur = rom[2][i2.note_index[1:0]];

  assign o_idx[0] = i0.note_index; assign o_on[0] = i0.note_on; assign o_busy[0] = i0.busy; assign o_done[0] = i0.song_done;
  assign o_idx[1] = i1.note_index; assign o_on[1] = i1.note_on; assign o_busy[1] = i1.busy; assign o_done[1] = i1.song_done;
  assign o_idx[2] = i2.note_index; assign o_on[2] = i2.note_on; assign o_busy[2] = i2.busy; assign o_done[2] = i2.song_done;

  song_sequencer #(.NUM_NOTES(4), .GAP_CYCLES(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  song_sequencer #(.NUM_NOTES(4), .GAP_CYCLES(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  song_sequencer #(.NUM_NOTES(2), .GAP_CYCLES(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit start;
    bit stop;
    int idx;
    bit on;
    bit busy;
    bit done;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    ntests++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s got %0d want %0d at %0t", nm, got, want, $time);
    end
  endtask

  function automatic int dur(input int k);
    int d;
    d = int'(rom[k][m_idx[k] % 4]);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic step_model();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n || sp[k]) begin
        m_act[k] = 0; m_done[k] = 0; m_idx[k] = 0; m_pos[k] = 0;
      end else if (!m_act[k]) begin
        if (st[k]) begin
          m_act[k] = 1; m_done[k] = 0; m_idx[k] = 0; m_pos[k] = 0;
        end
      end else if (m_pos[k] == 0) begin
        m_pos[k] = 1;
      end else if (!pa[k]) begin
        if (m_pos[k] == dur(k) + GG[k]) begin
          m_pos[k] = 0;
          if (m_idx[k] < NN[k] - 1) m_idx[k]++;
          else if (lp[k]) m_idx[k] = 0;
          else begin m_act[k] = 0; m_done[k] = 1; end
        end else begin
          m_pos[k]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_idx", k), 32'(o_idx[k]), m_idx[k]);
      chk($sformatf("d%0d_on", k), 32'(o_on[k]),
          32'(m_act[k] && m_pos[k] >= 1 && m_pos[k] <= dur(k)));
      chk($sformatf("d%0d_busy", k), 32'(o_busy[k]), 32'(m_act[k]));
      chk($sformatf("d%0d_done", k), 32'(o_done[k]), 32'(m_done[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    step_model();
    #1;
    check_all();
  endtask

  task automatic pulse_start(input int k);
    st[k] = 1; tick(); st[k] = 0;
  endtask

  task automatic pulse_stop(input int k);
    sp[k] = 1; tick(); sp[k] = 0;
  endtask

  task automatic set_rom(input int k, input int a, input int b, input int c, input int d);
    rom[k][0] = 29'(a); rom[k][1] = 29'(b); rom[k][2] = 29'(c); rom[k][3] = 29'(d);
  endtask

  function automatic vec_t mk(input bit s, input bit p, input int i, input bit o, input bit b, input bit d);
    vec_t v;
    v.start = s; v.stop = p; v.idx = i; v.on = o; v.busy = b; v.done = d;
    return v;
  endfunction

  initial begin
    int run, cnt;

    // start from DONE restarts; stop clears; stop in IDLE is a no-op
    vt[0]  = mk(1, 0, 0, 0, 1, 0);
    vt[1]  = mk(0, 0, 0, 1, 1, 0);
    vt[2]  = mk(0, 0, 0, 1, 1, 0);
    vt[3]  = mk(0, 0, 0, 1, 1, 0);
    vt[4]  = mk(0, 0, 1, 0, 1, 0);
    vt[5]  = mk(0, 0, 1, 1, 1, 0);
    vt[6]  = mk(0, 0, 2, 0, 1, 0);
    vt[7]  = mk(0, 0, 2, 1, 1, 0);
    vt[8]  = mk(0, 0, 3, 0, 1, 0);
    vt[9]  = mk(0, 0, 3, 1, 1, 0);
    vt[10] = mk(0, 0, 3, 1, 1, 0);
    vt[11] = mk(0, 0, 3, 0, 0, 1);
    vt[12] = mk(1, 0, 0, 0, 1, 0);
    vt[13] = mk(0, 1, 0, 0, 0, 0);
    vt[14] = mk(0, 1, 0, 0, 0, 0);

    for (int k = 0; k < 3; k++) begin
      st[k] = 0; sp[k] = 0; pa[k] = 0; lp[k] = 0;
    end
    set_rom(0, 3, 1, 0, 2);
    set_rom(1, 3, 1, 0, 2);
    set_rom(2, 2, 2, 0, 0);

    rst_n = 0;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_idx", 32'(o_idx[k]), 0);
      chk("rst_on", 32'(o_on[k]), 0);
      chk("rst_busy", 32'(o_busy[k]), 0);
      chk("rst_done", 32'(o_done[k]), 0);
    end
    rst_n = 1;
    tick();

    // basic song on instance 0, cycle by cycle
    for (int v = 0; v < 15; v++) begin
      st[0] = vt[v].start; sp[0] = vt[v].stop;
      tick();
      chk($sformatf("vec%0d_idx", v), 32'(o_idx[0]), vt[v].idx);
      chk($sformatf("vec%0d_on", v), 32'(o_on[0]), 32'(vt[v].on));
      chk($sformatf("vec%0d_busy", v), 32'(o_busy[0]), 32'(vt[v].busy));
      chk($sformatf("vec%0d_done", v), 32'(o_done[0]), 32'(vt[v].done));
    end
    st[0] = 0; sp[0] = 0;

    // gap of 2: 4 LOAD + 7 on + 8 gap cycles, DONE on the 20th edge
    pulse_start(1);
    cnt = 1;
    while (!o_done[1] && cnt < 100) begin tick(); cnt++; end
    chk("gap_total_edges", cnt, 20);
    chk("gap_last_idx", 32'(o_idx[1]), 3);

    // pause for 4 cycles from the 2nd note_on cycle stretches a 5-cycle note to 9
    set_rom(0, 5, 1, 1, 1);
    pulse_start(0);
    tick();
    run = o_on[0] ? 1 : 0;
    tick();
    if (o_on[0]) run++;
    pa[0] = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_on[0]) run++;
      chk("pause_idx_held", 32'(o_idx[0]), 0);
    end
    pa[0] = 0;
    cnt = 0;
    while (o_on[0] && cnt < 40) begin tick(); if (o_on[0]) run++; cnt++; end
    chk("pause_run_len", run, 9);
    chk("pause_next_idx", 32'(o_idx[0]), 1);
    pulse_stop(0);

    // looping two-note song, then drop loop_en during note 1
    lp[2] = 1;
    pulse_start(2);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin tick(); if (o_done[2]) cnt++; end
    chk("loop_no_done", cnt, 0);
    cnt = 0;
    while (!(o_idx[2] == 1 && o_on[2]) && cnt < 20) begin tick(); cnt++; end
    chk("loop_reach_idx1", 32'(o_idx[2] == 1 && o_on[2]), 1);
    lp[2] = 0;
    cnt = 0;
    while (!o_done[2] && cnt < 20) begin tick(); cnt++; end
    chk("loop_done", 32'(o_done[2]), 1);
    chk("loop_done_idx", 32'(o_idx[2]), 1);

    // stop and start together during PLAY of index 2
    set_rom(0, 3, 1, 0, 2);
    pulse_start(0);
    cnt = 0;
    while (!(o_idx[0] == 2 && o_on[0]) && cnt < 30) begin tick(); cnt++; end
    chk("stop_reach_idx2", 32'(o_idx[0] == 2 && o_on[0]), 1);
    st[0] = 1; sp[0] = 1;
    tick();
    st[0] = 0; sp[0] = 0;
    chk("stop_idx", 32'(o_idx[0]), 0);
    chk("stop_on", 32'(o_on[0]), 0);
    chk("stop_busy", 32'(o_busy[0]), 0);
    pulse_start(0);
    chk("restart_idx", 32'(o_idx[0]), 0);
    chk("restart_busy", 32'(o_busy[0]), 1);

    // start while busy is ignored, then reset in the middle of a gap
    pulse_start(1);
    cnt = 0;
    while (o_idx[1] != 1 && cnt < 30) begin tick(); cnt++; end
    pulse_start(1);
    chk("busy_start_idx", 32'(o_idx[1]), 1);
    cnt = 0;
    while (!(m_act[1] && m_pos[1] > dur(1)) && cnt < 40) begin tick(); cnt++; end
    chk("reach_gap", 32'(o_busy[1] && !o_on[1]), 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("midgap_rst_idx", 32'(o_idx[1]), 0);
    chk("midgap_rst_busy", 32'(o_busy[1]), 0);
    chk("midgap_rst_on", 32'(o_on[1]), 0);
    chk("midgap_rst_done", 32'(o_done[1]), 0);

    // randomized traffic with fixed random ROM contents
    rst_n = 0;
    tick();
    for (int k = 0; k < 3; k++)
      set_rom(k, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
    rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        st[k] = ($urandom % 8) == 0;
        sp[k] = ($urandom % 64) == 0;
        pa[k] = ($urandom % 4) == 0;
        lp[k] = ($urandom % 2) == 0;
      end
      rst_n = ($urandom % 500) != 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Plays a song by stepping through its notes in order and timing each one.
- Drives note_index into the per-song duration ROM and the pitch ROM, then loads the returned note_dur into a down-counter.
- Holds note_on high for exactly that many cycles, inserts an optional articulation gap, and advances to the next note.
- Sits between the top-level play/stop controls and the tone generator that consumes note_index and note_on.

Parameters:
- NUM_NOTES, 8, number of valid notes in the song (1..2048); the last index is NUM_NOTES-1.
- GAP_CYCLES, 0, silent cycles inserted after each note (0..2^29-1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- start  in  1  single-cycle pulse; begins playback from note 0
- stop  in  1  single-cycle pulse; aborts playback
- pause  in  1  level; freezes all timing while high
- loop_en  in  1  level; after the last note, restart at note 0 instead of finishing
- note_dur  in  29  duration in clk cycles for the current note_index (combinational ROM return)
- note_index  out  11  index presented to the duration and pitch ROMs
- note_on  out  1  high while the current note sounds
- busy  out  1  high in LOAD, PLAY and GAP
- song_done  out  1  high while in DONE

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, note_index=0, note_on=0, busy=0, song_done=0, both counters=0.
- Outputs are registered.
- States are IDLE, LOAD, PLAY, GAP and DONE.
- IDLE/DONE:
  - start=1 -> LOAD with note_index=0; song_done clears on the same edge.
  - start while busy is ignored.
- LOAD (always 1 cycle, note_on=0):
  - dur_cnt <= (note_dur==0) ? 1 : note_dur. A zero duration is treated as 1.
  - Next state is PLAY.
  - pause does not stall LOAD.
- PLAY (note_on=1):
  - pause=0: dur_cnt decrements each cycle.
  - pause=1: dur_cnt holds and note_on stays 1.
  - When dur_cnt==1 and pause=0: go to GAP with gap_cnt=GAP_CYCLES if GAP_CYCLES>0, otherwise ADVANCE.
  - Unpaused, note_on is high for exactly max(note_dur,1) cycles.
- GAP (note_on=0): gap_cnt decrements unless paused; ADVANCE when gap_cnt==1 and pause=0.
- ADVANCE (a transition, not a state):
  - note_index < NUM_NOTES-1: note_index+1 -> LOAD.
  - note_index == NUM_NOTES-1 and loop_en=1: note_index=0 -> LOAD.
  - Otherwise -> DONE, leaving note_index at NUM_NOTES-1.
  - loop_en is sampled at ADVANCE only.
- Note period (unpaused) = max(note_dur,1) + GAP_CYCLES + 1 (the LOAD cycle).
- stop=1 in any state -> IDLE next edge with note_index=0, note_on=0 and both counters cleared.
  - stop beats start in the same cycle.
  - stop beats an ADVANCE in the same cycle.
  - stop in IDLE is a no-op.
- Reset mid-song behaves as stop, plus song_done clears.
- note_index never exceeds NUM_NOTES-1.
- Counters are 29-bit unsigned with no wrap: the ==1 check precedes the decrement.
- note_index must be stable for the whole LOAD cycle. note_dur is sampled only in LOAD.

Decomposition:
- Package song_pkg:
  - IDX_W=11, DUR_W=29
  - typedef logic [IDX_W-1:0] note_idx_t
  - typedef logic [DUR_W-1:0] note_dur_t
  - enum seq_state_t {IDLE, LOAD, PLAY, GAP, DONE}
- One sub-module, dur_counter: load value, enable, zero-clamped load, expire flag when count==1 && en. It is instantiated twice, for the duration and the gap.

Test Plan:
- NUM_NOTES=4, GAP_CYCLES=0, stub ROM returns {3,1,0,2}, start pulse -> note_on high for runs of 3,1,1,2 cycles, each preceded by a 1-cycle low (LOAD); note_index 0,1,2,3; song_done rises 1 cycle after the last note_on falls; total 11 cycles from start to DONE.
- Same ROM, GAP_CYCLES=2 -> each note_on run followed by 3 low cycles (2 gap + LOAD); index advance occurs at the gap end.
- Durations {5,...}, pause high for 4 cycles starting on the 2nd note_on cycle -> note_on lasts 9 cycles; index unchanged until expiry.
- loop_en=1, NUM_NOTES=2, ROM {2,2} -> note_index sequence 0,1,0,1,...; song_done never asserts; deassert loop_en during note 1 -> DONE after it.
- stop during PLAY of index 2 with start asserted the same cycle -> next edge IDLE, note_index=0, note_on=0, busy=0; a later start replays from index 0.
- rst_n low for 1 cycle mid-GAP, and start during busy -> reset values on all outputs; start while busy causes no index change.
